// File: rtl/bus_pkg.sv
// Shared definitions for the core memory bus: transfer size, word size,
// copy-master state encoding and error codes. Also used by memory responders.
package bus_pkg;

    localparam logic [1:0]  DSIZE_32   = 2'd2;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BUSX    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ALIGN   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP_R,
        ST_WR,
        ST_GAP_W,
        ST_DONE,
        ST_FAULT
    } copy_state_t;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Per-access wait timer for bus initiators.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : hold the count at zero
//   tick         : one waiting cycle elapsed
//   expired      : this tick is the TIMEOUT-th waiting cycle (never when TIMEOUT=0)
module bus_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [W-1:0] cnt;
    logic         at_limit;

    assign at_limit = (cnt == LIMIT[W-1:0]);
    assign expired  = (TIMEOUT != 0) && tick && at_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_copy_master.sv
// Bus copy master: second initiator on the core memory bus. Copies cmd_count
// 32-bit words from cmd_src to cmd_dst, one read/write pair per word, and
// reports completion (done) or a fault (error, err_code, err_addr).
// Ports:
//   clk, reset_n                    : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             : command handshake (ready only when idle)
//   cmd_src, cmd_dst, cmd_count     : word-aligned byte addresses, word count
//   busy, done, error               : status; done/error are one-cycle pulses
//   err_addr, err_code              : failing access, held until next command
//   address, dsize, dout            : bus request fields
//   readmem, writemem               : request levels held until response
//   din, ready, busx                : responder data, completion, exception
module bus_copy_master
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        dsize,
    output logic [DATA_W-1:0] dout,
    output logic              readmem,
    output logic              writemem,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    input  logic              busx
);

    copy_state_t       state, state_n;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic [1:0]        err_code_q;
    logic              error_q;

    logic              accept, latch_word, advance, fault;
    logic [1:0]        fault_code;
    logic [ADDR_W-1:0] fault_addr;
    logic              in_access, tmr_expired, bus_quiet;

    logic unused_din_hi;
    assign unused_din_hi = ^din[DATA_W-1:32];

    assign in_access = (state == ST_RD) || (state == ST_WR);
    assign bus_quiet = !ready && !busx;

    // Holding the timer clear outside RD/WR restarts it on every access entry.
    bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_access),
        .tick    (in_access),
        .expired (tmr_expired)
    );

    // Bus and status outputs decode the state directly so an asynchronous
    // reset drops the request lines immediately.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign error     = error_q;
    assign err_addr  = err_addr_q;
    assign err_code  = err_code_q;
    assign dsize     = DSIZE_32;
    assign readmem   = (state == ST_RD);
    assign writemem  = (state == ST_WR);
    assign address   = (state == ST_RD) ? src_q :
                       (state == ST_WR) ? dst_q : '0;
    assign dout      = (state == ST_WR) ? {{(DATA_W-32){1'b0}}, word_q} : '0;

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        latch_word = 1'b0;
        advance    = 1'b0;
        fault      = 1'b0;
        fault_code = ERR_NONE;
        fault_addr = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_count == '0) begin
                        state_n = ST_DONE;
                    end else if (misaligned(cmd_src[1:0])) begin
                        fault      = 1'b1;
                        fault_code = ERR_ALIGN;
                        fault_addr = cmd_src;
                        state_n    = ST_FAULT;
                    end else if (misaligned(cmd_dst[1:0])) begin
                        fault      = 1'b1;
                        fault_code = ERR_ALIGN;
                        fault_addr = cmd_dst;
                        state_n    = ST_FAULT;
                    end else begin
                        state_n = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // busx takes priority over a simultaneous ready
                if (busx) begin
                    fault      = 1'b1;
                    fault_code = ERR_BUSX;
                    fault_addr = src_q;
                    state_n    = ST_FAULT;
                end else if (ready) begin
                    latch_word = 1'b1;
                    state_n    = ST_GAP_R;
                end else if (tmr_expired) begin
                    fault      = 1'b1;
                    fault_code = ERR_TIMEOUT;
                    fault_addr = src_q;
                    state_n    = ST_FAULT;
                end
            end
            ST_GAP_R: begin
                if (bus_quiet) state_n = ST_WR;
            end
            ST_WR: begin
                if (busx) begin
                    fault      = 1'b1;
                    fault_code = ERR_BUSX;
                    fault_addr = dst_q;
                    state_n    = ST_FAULT;
                end else if (ready) begin
                    advance = 1'b1;
                    state_n = ST_GAP_W;
                end else if (tmr_expired) begin
                    fault      = 1'b1;
                    fault_code = ERR_TIMEOUT;
                    fault_addr = dst_q;
                    state_n    = ST_FAULT;
                end
            end
            ST_GAP_W: begin
                if (bus_quiet) state_n = (cnt_q == '0) ? ST_DONE : ST_RD;
            end
            ST_DONE:  state_n = ST_IDLE;
            ST_FAULT: begin
                if (bus_quiet) state_n = ST_IDLE;
            end
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            err_addr_q <= '0;
            err_code_q <= ERR_NONE;
            error_q    <= 1'b0;
        end else begin
            state   <= state_n;
            error_q <= fault;
            if (accept) begin
                src_q      <= cmd_src;
                dst_q      <= cmd_dst;
                cnt_q      <= cmd_count;
                err_addr_q <= '0;
                err_code_q <= ERR_NONE;
            end
            if (latch_word) word_q <= din[31:0];
            if (advance) begin
                src_q <= src_q + ADDR_W'(WORD_BYTES);
                dst_q <= dst_q + ADDR_W'(WORD_BYTES);
                cnt_q <= cnt_q - 1'b1;
            end
            // A misaligned command faults in the accept cycle; the fault
            // assignment comes last so it overrides the clear.
            if (fault) begin
                err_addr_q <= fault_addr;
                err_code_q <= fault_code;
            end
        end
    end

endmodule

// File: tb/tb_bus_copy_master.sv
module tb_bus_copy_master;
    import bus_pkg::*;

    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 64;
    localparam int CNT_W     = 16;
    localparam int TMO       = 8;
    localparam int RAM_WORDS = 8191;

    logic              clk, reset_n;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_src, cmd_dst;
    logic [CNT_W-1:0]  cmd_count;
    logic              busy, done, error;
    logic [ADDR_W-1:0] err_addr;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] address;
    logic [1:0]        dsize;
    logic [DATA_W-1:0] dout, din;
    logic              readmem, writemem, ready, busx;

    bus_copy_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_count (cmd_count),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr),
        .err_code  (err_code),
        .address   (address),
        .dsize     (dsize),
        .dout      (dout),
        .readmem   (readmem),
        .writemem  (writemem),
        .din       (din),
        .ready     (ready),
        .busx      (busx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM responder: registered ready/busx one cycle after a request
    logic [31:0] ram [RAM_WORDS];
    logic        hang;
    int          rd_resp, wr_resp, rd_cyc, wr_cyc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
            busx  <= 1'b0;
            din   <= '0;
        end else begin
            ready <= 1'b0;
            busx  <= 1'b0;
            if ((readmem || writemem) && !ready && !busx && !hang) begin
                if (address >= 64'(RAM_WORDS * 4)) begin
                    busx <= 1'b1;
                end else begin
                    ready <= 1'b1;
                    if (readmem) begin
                        din <= {32'h0, ram[address[14:2]]};
                        rd_resp++;
                    end else begin
                        ram[address[14:2]] <= dout[31:0];
                        wr_resp++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (readmem)  rd_cyc++;
        if (writemem) wr_cyc++;
    end

    // Scoreboard
    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [63:0] addr;
    } resp_t;

    resp_t exp_q[$];
    int    total, bad, resp_seen;
    time   resp_time, acc_time;

    always @(negedge clk) begin
        if (reset_n && (done || error)) begin
            resp_seen++;
            resp_time = $time;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp done=%0b error=%0b code=%0d addr=%0h",
                         done, error, err_code, err_addr);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                if (done !== !e.is_err || error !== e.is_err ||
                    err_code !== e.code || err_addr !== e.addr) begin
                    bad++;
                    $display("FAIL resp got done=%0b error=%0b code=%0d addr=%0h want error=%0b code=%0d addr=%0h",
                             done, error, err_code, err_addr, e.is_err, e.code, e.addr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_resp(input logic is_err, input logic [1:0] code, input logic [63:0] addr);
        resp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.addr   = addr;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [63:0] s, input logic [63:0] d, input logic [15:0] c);
        int n;
        @(posedge clk); #1;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_count = c;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", {63'h0, cmd_ready}, 64'h1);
        @(posedge clk);
        acc_time = $time;
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n0);
        int k;
        k = 0;
        while (resp_seen == n0 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        if (resp_seen == n0) chk("resp_timeout", 64'(resp_seen), 64'(n0 + 1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        rd_resp = 0; wr_resp = 0; rd_cyc = 0; wr_cyc = 0;
    endtask

    localparam logic [31:0] WA = 32'hA1A1_0001;
    localparam logic [31:0] WB = 32'hB2B2_0002;
    localparam logic [31:0] WC = 32'hC3C3_0003;
    localparam logic [31:0] SENT = 32'h5EA7_1E55;

    initial begin
        int n0, k;
        total = 0; bad = 0; resp_seen = 0;
        hang = 1'b0;
        cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_count = '0;
        clr_counts();
        for (int i = 0; i < RAM_WORDS; i++) ram[i] = 32'h0;
        ram[4] = WA; ram[5] = WB; ram[6] = WC;
        ram[8189] = SENT;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        chk("rst_busy",      {63'h0, busy},      64'h0);
        chk("rst_done_err",  {62'h0, done, error}, 64'h0);
        chk("rst_req",       {62'h0, readmem, writemem}, 64'h0);
        chk("rst_dsize",     {62'h0, dsize},     64'h2);
        chk("rst_err",       err_addr | {62'h0, err_code}, 64'h0);
        chk("rst_bus",       address | dout,     64'h0);
        reset_n = 1'b1;

        // 3-word copy
        clr_counts();
        n0 = resp_seen;
        expect_resp(1'b0, ERR_NONE, 64'h0);
        issue(64'd16, 64'd64, 16'd3);
        wait_resp(n0);
        chk("copy3_w0", {32'h0, ram[16]}, {32'h0, WA});
        chk("copy3_w1", {32'h0, ram[17]}, {32'h0, WB});
        chk("copy3_w2", {32'h0, ram[18]}, {32'h0, WC});
        chk("copy3_reads",  64'(rd_resp), 64'd3);
        chk("copy3_writes", 64'(wr_resp), 64'd3);
        chk("copy3_idle",   {62'h0, busy, cmd_ready}, 64'h1);

        // zero count: done in the cycle right after accept, no traffic
        clr_counts();
        n0 = resp_seen;
        expect_resp(1'b0, ERR_NONE, 64'h0);
        issue(64'd100, 64'd200, 16'd0);
        wait_resp(n0);
        chk("cnt0_latency", 64'(resp_time - acc_time), 64'd5);
        chk("cnt0_no_bus",  64'(rd_cyc + wr_cyc), 64'd0);

        // misaligned source, then misaligned destination
        clr_counts();
        n0 = resp_seen;
        expect_resp(1'b1, ERR_ALIGN, 64'd6);
        issue(64'd6, 64'd64, 16'd2);
        wait_resp(n0);
        chk("align_no_bus", 64'(rd_cyc + wr_cyc), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("align_held_addr", err_addr, 64'd6);
        chk("align_held_code", {62'h0, err_code}, 64'd3);
        n0 = resp_seen;
        expect_resp(1'b1, ERR_ALIGN, 64'd66);
        issue(64'd16, 64'd66, 16'd1);
        wait_resp(n0);

        // destination runs off the end: word 8190 is the last mapped one,
        // so the second write (address 32764) takes busx
        clr_counts();
        n0 = resp_seen;
        expect_resp(1'b1, ERR_BUSX, 64'd32764);
        issue(64'd16, 64'd32760, 16'd3);
        wait_resp(n0);
        chk("busx_last_word", {32'h0, ram[8190]}, {32'h0, WA});
        chk("busx_below",     {32'h0, ram[8189]}, {32'h0, SENT});
        chk("busx_reads",     64'(rd_resp), 64'd2);
        chk("busx_writes",    64'(wr_resp), 64'd1);
        chk("busx_busy",      {63'h0, busy}, 64'h0);
        chk("busx_code",      {62'h0, err_code}, 64'd1);

        // hung responder: timeout after TMO cycles in RD
        clr_counts();
        hang = 1'b1;
        n0 = resp_seen;
        expect_resp(1'b1, ERR_TIMEOUT, 64'd64);
        issue(64'd64, 64'd512, 16'd1);
        wait_resp(n0);
        chk("tmo_rd_cycles", 64'(rd_cyc), 64'(TMO));
        chk("tmo_no_write",  64'(wr_cyc), 64'd0);
        hang = 1'b0;

        // reset in the middle of a write
        issue(64'd16, 64'd128, 16'd3);
        k = 0;
        while (!writemem && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rstwr_reached_wr", {63'h0, writemem}, 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstwr_async_drop", {62'h0, writemem, readmem}, 64'h0);
        chk("rstwr_idle",       {62'h0, cmd_ready, busy}, 64'h2);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rstwr_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        n0 = resp_seen;
        expect_resp(1'b0, ERR_NONE, 64'h0);
        issue(64'd16, 64'd192, 16'd3);
        wait_resp(n0);
        chk("rstwr_copy_w0", {32'h0, ram[48]}, {32'h0, WA});
        chk("rstwr_copy_w1", {32'h0, ram[49]}, {32'h0, WB});
        chk("rstwr_copy_w2", {32'h0, ram[50]}, {32'h0, WC});

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
